// File: rtl/fetch_stage_if.sv
// fetch_stage_if - instruction-memory request/response bus.
//
// The fetch stage is the master: it presents imem_addr/imem_rmask and holds
// them until the single-cycle imem_resp strobe arrives with imem_rdata.
// The instruction memory is the slave.
//
// Signals:
//   imem_addr   [31:0]  fetch address (master -> slave)
//   imem_rmask  [3:0]   4'hF while a request is active, else 4'h0
//   imem_resp           response strobe for the active request (slave -> master)
//   imem_rdata  [31:0]  instruction word, valid with imem_resp
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_resp;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_rmask,
        input  imem_resp,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_rmask,
        output imem_resp,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage - instruction-fetch stage feeding decode.
//
// Owns the PC, issues one outstanding request at a time on the instruction
// memory bus, buffers a single fetched word while decode stalls, and squashes
// in-flight fetches on a redirect. All outputs are registered.
//
// Ports:
//   clk                  clock, all state updates on posedge
//   rst_n                synchronous active-low reset
//   stall                downstream hazard; if_* outputs hold while high
//   redirect_valid       flush and restart fetch at redirect_pc
//   redirect_pc  [31:0]  redirect target, bits [1:0] forced to zero
//   imem                 fetch_stage_if.master instruction-memory bus
//   if_valid             if_* outputs carry a live instruction
//   if_pc        [31:0]  PC of the instruction
//   if_pc_next   [31:0]  if_pc + 4
//   if_order     [ORDER_W-1:0] consecutive sequence number
//   if_inst      [31:0]  instruction word
//   perf_stall_cycles [31:0]  saturating stall-cycle counter
//   perf_drops   [31:0]  saturating discarded-response counter
//
// Build option: define FETCH_PERF_EN to enable the performance counters;
// without it both perf outputs are tied to zero and the port list is unchanged.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          ORDER_W  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    fetch_stage_if.master      imem,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_next,
    output logic [ORDER_W-1:0] if_order,
    output logic [31:0]        if_inst,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_drops
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    localparam logic [ORDER_W-1:0] ORDER_ZERO = {ORDER_W{1'b0}};
    localparam logic [ORDER_W-1:0] ORDER_ONE  = {{(ORDER_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [31:0]         pc_r;
    logic [ORDER_W-1:0]  order_r;
    logic [31:0]         imem_addr_r;
    logic [3:0]          imem_rmask_r;

    logic                if_valid_r;
    logic [31:0]         if_pc_r;
    logic [31:0]         if_pc_next_r;
    logic [ORDER_W-1:0]  if_order_r;
    logic [31:0]         if_inst_r;

    // One-entry skid buffer; it is only meaningful while state_r is S_HOLD,
    // so leaving HOLD (or a redirect) empties it without touching the data.
    logic [31:0]         buf_pc_r;
    logic [31:0]         buf_inst_r;
    logic [ORDER_W-1:0]  buf_order_r;

    logic [31:0]         redirect_target_s;
    logic [31:0]         pc_inc_s;
    logic [31:0]         buf_pc_inc_s;
    logic [ORDER_W-1:0]  order_inc_s;

    assign redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
    assign pc_inc_s          = pc_r + 32'd4;
    assign buf_pc_inc_s      = buf_pc_r + 32'd4;
    assign order_inc_s       = order_r + ORDER_ONE;

    assign imem.imem_addr  = imem_addr_r;
    assign imem.imem_rmask = imem_rmask_r;

    assign if_valid   = if_valid_r;
    assign if_pc      = if_pc_r;
    assign if_pc_next = if_pc_next_r;
    assign if_order   = if_order_r;
    assign if_inst    = if_inst_r;

    // Fetch FSM: PC, order counter, memory request, skid buffer and if_* outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            pc_r         <= RESET_PC;
            order_r      <= ORDER_ZERO;
            imem_addr_r  <= RESET_PC;
            imem_rmask_r <= 4'h0;
            if_valid_r   <= 1'b0;
            if_pc_r      <= 32'h0000_0000;
            if_pc_next_r <= 32'h0000_0000;
            if_order_r   <= ORDER_ZERO;
            if_inst_r    <= 32'h0000_0000;
            buf_pc_r     <= 32'h0000_0000;
            buf_inst_r   <= 32'h0000_0000;
            buf_order_r  <= ORDER_ZERO;
        end else if (redirect_valid) begin
            // Redirect wins over stall and over a same-cycle response; the
            // squashed word never consumes an order number.
            pc_r       <= redirect_target_s;
            if_valid_r <= 1'b0;
            if (((state_r == S_FETCH) || (state_r == S_DROP)) && !imem.imem_resp) begin
                // Request still outstanding: keep it on the bus and throw
                // away its response when it arrives.
                state_r <= S_DROP;
            end else begin
                state_r      <= S_FETCH;
                imem_addr_r  <= redirect_target_s;
                imem_rmask_r <= 4'hF;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    // A stale response from before reset is ignored here.
                    state_r      <= S_FETCH;
                    imem_addr_r  <= pc_r;
                    imem_rmask_r <= 4'hF;
                end
                S_FETCH: begin
                    if (imem.imem_resp) begin
                        order_r     <= order_inc_s;
                        pc_r        <= pc_inc_s;
                        imem_addr_r <= pc_inc_s;
                        if (!stall) begin
                            if_valid_r   <= 1'b1;
                            if_pc_r      <= pc_r;
                            if_pc_next_r <= pc_inc_s;
                            if_order_r   <= order_r;
                            if_inst_r    <= imem.imem_rdata;
                        end else begin
                            // Decode is blocked: park the word and pause fetching.
                            buf_pc_r     <= pc_r;
                            buf_inst_r   <= imem.imem_rdata;
                            buf_order_r  <= order_r;
                            imem_rmask_r <= 4'h0;
                            state_r      <= S_HOLD;
                        end
                    end else if (!stall) begin
                        if_valid_r <= 1'b0;
                    end else begin
                        if_valid_r <= if_valid_r;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_valid_r   <= 1'b1;
                        if_pc_r      <= buf_pc_r;
                        if_pc_next_r <= buf_pc_inc_s;
                        if_order_r   <= buf_order_r;
                        if_inst_r    <= buf_inst_r;
                        imem_addr_r  <= pc_r;
                        imem_rmask_r <= 4'hF;
                        state_r      <= S_FETCH;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if_valid_r <= 1'b0;
                    if (imem.imem_resp) begin
                        imem_addr_r  <= pc_r;
                        imem_rmask_r <= 4'hF;
                        state_r      <= S_FETCH;
                    end else begin
                        state_r <= S_DROP;
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    imem_rmask_r <= 4'h0;
                    if_valid_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles_r;
    logic [31:0] perf_drops_r;
    logic        stall_event_s;
    logic        drop_event_s;

    assign stall_event_s = stall && ((state_r == S_FETCH) || (state_r == S_HOLD));
    assign drop_event_s  = imem.imem_resp &&
                           ((state_r == S_DROP) || ((state_r == S_FETCH) && redirect_valid));

    // Saturating performance counters for stall cycles and discarded responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cycles_r <= 32'h0000_0000;
            perf_drops_r        <= 32'h0000_0000;
        end else begin
            if (stall_event_s && (perf_stall_cycles_r != 32'hFFFF_FFFF)) begin
                perf_stall_cycles_r <= perf_stall_cycles_r + 32'd1;
            end
            if (drop_event_s && (perf_drops_r != 32'hFFFF_FFFF)) begin
                perf_drops_r <= perf_drops_r + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_cycles_r;
    assign perf_drops        = perf_drops_r;
`else
    assign perf_stall_cycles = 32'h0000_0000;
    assign perf_drops        = 32'h0000_0000;
`endif

endmodule
